// File: rtl/kalman_calibration.sv
// kalman_calibration: start-up bias calibration for the MPU6050 attitude pipeline.
// Once sensor configuration is done, it averages 2^SAMPLE_LOG2 raw 7-channel samples.
// It presents the signed mean of each channel as that channel's bias.
// Ports:
//   clk_in, rst_n          - clock, asynchronous active-low reset
//   *_in (7 channels)      - signed raw samples (acc x/y/z, temp, gyro x/y/z)
//   i2c_ack_5_pos_in       - one-cycle strobe: a new sample set is on the inputs
//   config_done            - level; calibration only runs while high
//   key_flag_in            - one-cycle request to restart calibration
//   calib_done_out         - high while bias outputs hold a valid result
//   *_bias_out (7 channels) - signed mean, truncated toward zero
module kalman_calibration #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SAMPLE_LOG2 = 10,
  parameter int unsigned SUM_W       = DATA_W + SAMPLE_LOG2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] acc_x_in,
  input  logic [DATA_W-1:0] acc_y_in,
  input  logic [DATA_W-1:0] acc_z_in,
  input  logic [DATA_W-1:0] temp_in,
  input  logic [DATA_W-1:0] gyro_x_in,
  input  logic [DATA_W-1:0] gyro_y_in,
  input  logic [DATA_W-1:0] gyro_z_in,
  input  logic              i2c_ack_5_pos_in,
  input  logic              config_done,
  input  logic              key_flag_in,
  output logic              calib_done_out,
  output logic [DATA_W-1:0] acc_x_bias_out,
  output logic [DATA_W-1:0] acc_y_bias_out,
  output logic [DATA_W-1:0] acc_z_bias_out,
  output logic [DATA_W-1:0] temp_bias_out,
  output logic [DATA_W-1:0] gyro_x_bias_out,
  output logic [DATA_W-1:0] gyro_y_bias_out,
  output logic [DATA_W-1:0] gyro_z_bias_out
);

  localparam int unsigned NumCh = 7;
  localparam logic [SUM_W-1:0] RoundAdj = SUM_W'((2 ** SAMPLE_LOG2) - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDivide, StDone} state_e;

  state_e                   state_q, state_d;
  logic [SAMPLE_LOG2:0]     cnt_q, cnt_d;
  logic signed [SUM_W-1:0]  sum_q [NumCh];
  logic signed [SUM_W-1:0]  sum_d [NumCh];
  logic [DATA_W-1:0]        bias_q [NumCh];
  logic [DATA_W-1:0]        bias_d [NumCh];
  logic                     done_q, done_d;
  logic [DATA_W-1:0]        sample [NumCh];

  assign sample[0] = acc_x_in;
  assign sample[1] = acc_y_in;
  assign sample[2] = acc_z_in;
  assign sample[3] = temp_in;
  assign sample[4] = gyro_x_in;
  assign sample[5] = gyro_y_in;
  assign sample[6] = gyro_z_in;

  // Signed divide by 2^SAMPLE_LOG2 rounding toward zero: bias negative sums up before the shift.
  function automatic logic [DATA_W-1:0] trunc_div(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] r;
    r = s[SUM_W-1] ? $signed(s + RoundAdj) : s;
    r = r >>> SAMPLE_LOG2;
    return r[DATA_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    bias_d  = bias_q;
    done_d  = done_q;
    if (key_flag_in) begin
      // Restart wins over everything, including a same-cycle strobe.
      state_d = StIdle;
      cnt_d   = '0;
      sum_d   = '{default: '0};
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (config_done) state_d = StAccum;
        end
        StAccum: begin
          if (!config_done) begin
            state_d = StIdle;
            cnt_d   = '0;
            sum_d   = '{default: '0};
          end else if (cnt_q[SAMPLE_LOG2]) begin
            // Counter full: stop accumulating and divide next cycle.
            state_d = StDivide;
          end else if (i2c_ack_5_pos_in) begin
            for (int i = 0; i < NumCh; i++) begin
              sum_d[i] = sum_q[i] + SUM_W'($signed(sample[i]));
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDivide: begin
          if (!config_done) begin
            state_d = StIdle;
            cnt_d   = '0;
            sum_d   = '{default: '0};
          end else begin
            for (int i = 0; i < NumCh; i++) begin
              bias_d[i] = trunc_div(sum_q[i]);
            end
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sum_q   <= '{default: '0};
      bias_q  <= '{default: '0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      bias_q  <= bias_d;
      done_q  <= done_d;
    end
  end

  assign calib_done_out  = done_q;
  assign acc_x_bias_out  = bias_q[0];
  assign acc_y_bias_out  = bias_q[1];
  assign acc_z_bias_out  = bias_q[2];
  assign temp_bias_out   = bias_q[3];
  assign gyro_x_bias_out = bias_q[4];
  assign gyro_y_bias_out = bias_q[5];
  assign gyro_z_bias_out = bias_q[6];

endmodule

// File: tb/tb_kalman_calibration.sv
// Bench for kalman_calibration: a behavioural average model plus per-cycle output comparison.
module tb_kalman_calibration;

  localparam int N = 1024;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] in_v [7];
  logic [15:0] out_v [7];
  logic        stb = 1'b0;
  logic        cfg = 1'b0;
  logic        key = 1'b0;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: running sums, samples counted, cycles until result appears.
  longint      m_sum [7];
  int          m_n    = 0;
  int          m_wait = 0;
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_bias [7];
  bit          cmp_en = 1'b0;

  always #5 clk_in = ~clk_in;

  kalman_calibration dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .acc_x_in         (in_v[0]),
    .acc_y_in         (in_v[1]),
    .acc_z_in         (in_v[2]),
    .temp_in          (in_v[3]),
    .gyro_x_in        (in_v[4]),
    .gyro_y_in        (in_v[5]),
    .gyro_z_in        (in_v[6]),
    .i2c_ack_5_pos_in (stb),
    .config_done      (cfg),
    .key_flag_in      (key),
    .calib_done_out   (done),
    .acc_x_bias_out   (out_v[0]),
    .acc_y_bias_out   (out_v[1]),
    .acc_z_bias_out   (out_v[2]),
    .temp_bias_out    (out_v[3]),
    .gyro_x_bias_out  (out_v[4]),
    .gyro_y_bias_out  (out_v[5]),
    .gyro_z_bias_out  (out_v[6])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model_sums();
    for (int i = 0; i < 7; i++) m_sum[i] = 0;
    m_n    = 0;
    m_wait = 0;
  endtask

  // Reference model: mean of the counted samples, truncated toward zero by integer division.
  initial begin
    for (int i = 0; i < 7; i++) begin
      m_sum[i]  = 0;
      m_bias[i] = '0;
    end
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        clear_model_sums();
        m_run  = 1'b0;
        m_done = 1'b0;
        for (int i = 0; i < 7; i++) m_bias[i] = '0;
      end else if (key) begin
        clear_model_sums();
        m_run  = 1'b0;
        m_done = 1'b0;
      end else if (m_run) begin
        if (!cfg) begin
          clear_model_sums();
          m_run = 1'b0;
        end else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            for (int i = 0; i < 7; i++) m_bias[i] = 16'(m_sum[i] / N);
            m_done = 1'b1;
            m_run  = 1'b0;
          end
        end else if (stb) begin
          for (int i = 0; i < 7; i++) m_sum[i] += longint'($signed(in_v[i]));
          m_n++;
          if (m_n == N) m_wait = 2;
        end
      end else if (!m_done && cfg) begin
        m_run = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk_in);
      if (cmp_en) begin
        chk("calib_done", int'(done), int'(m_done));
        for (int i = 0; i < 7; i++) begin
          chk($sformatf("bias[%0d]", i), int'($signed(out_v[i])), int'($signed(m_bias[i])));
        end
      end
    end
  end

  // One strobe; occasionally leave an idle gap so back-to-back strobes also occur.
  task automatic strobe(input logic [15:0] a, b, c, d, e, f, g);
    in_v[0] = a; in_v[1] = b; in_v[2] = c; in_v[3] = d;
    in_v[4] = e; in_v[5] = f; in_v[6] = g;
    stb = 1'b1;
    @(negedge clk_in);
    if ($urandom_range(2) == 0) begin
      stb = 1'b0;
      repeat ($urandom_range(2)) @(negedge clk_in);
    end
  endtask

  function automatic logic [15:0] noisy(input int base);
    int n;
    n = int'($urandom_range(38)) - 19;
    return 16'(base + n);
  endfunction

  task automatic pulse_key();
    key = 1'b1;
    @(negedge clk_in);
    key = 1'b0;
  endtask

  task automatic finish_wait();
    stb = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) in_v[i] = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_done", int'(done), 0);
    chk("reset_bias_ax", int'(out_v[0]), 0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    cfg   = 1'b1;
    repeat (2) @(negedge clk_in);

    // 1: constant inputs
    for (int k = 0; k < N; k++) strobe(16'd1353, -16'sd370, -16'sd68, -16'sd20,
                                       -16'sd112, -16'sd35, -16'sd44);
    finish_wait();
    chk("t1_done", int'(done), 1);
    chk("t1_ax", int'($signed(out_v[0])), 1353);
    chk("t1_ay", int'($signed(out_v[1])), -370);
    chk("t1_tmp", int'($signed(out_v[3])), -20);
    chk("t1_gz", int'($signed(out_v[6])), -44);

    // 2: noisy inputs around the same base
    pulse_key();
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < N; k++) strobe(noisy(1353), noisy(-370), noisy(-68), noisy(-20),
                                       noisy(-112), noisy(-35), noisy(-44));
    finish_wait();
    chk("t2_done", int'(done), 1);

    // 3: rounding toward zero
    pulse_key();
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < N - 1; k++) strobe(16'hffff, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    strobe(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    finish_wait();
    chk("t3_ax_trunc", int'($signed(out_v[0])), 0);
    chk("t3_ay_trunc", int'($signed(out_v[1])), 0);

    // 4: strobes before config_done are ignored
    cfg = 1'b0;
    pulse_key();
    for (int k = 0; k < 20; k++) strobe(16'd999, 16'd999, 16'd999, 16'd999, 16'd999, 16'd999,
                                        16'd999);
    stb = 1'b0;
    cfg = 1'b1;
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < N; k++) strobe(16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
    finish_wait();
    chk("t4_ax", int'($signed(out_v[0])), 5);
    chk("t4_gz", int'($signed(out_v[6])), 5);

    // 5: restart by key (with a simultaneous, discarded strobe); old biases held
    in_v[0] = 16'd7000;
    stb = 1'b1;
    pulse_key();
    stb = 1'b0;
    chk("t5_done_drop", int'(done), 0);
    chk("t5_hold_ax", int'($signed(out_v[0])), 5);
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < N; k++) strobe(16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100,
                                       16'd100);
    finish_wait();
    chk("t5_done", int'(done), 1);
    chk("t5_ax", int'($signed(out_v[0])), 100);

    // 6: asynchronous reset in the middle of accumulation
    pulse_key();
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < 500; k++) strobe(noisy(3000), noisy(-3000), noisy(0), noisy(50),
                                         noisy(10), noisy(-10), noisy(200));
    stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_ax", int'(out_v[0]), 0);
    chk("t6_rst_gz", int'(out_v[6]), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < N; k++) strobe(noisy(-500), noisy(20), noisy(16000), noisy(-7),
                                       noisy(0), noisy(33), noisy(-1));
    finish_wait();
    chk("t6_done", int'(done), 1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
